attack_sequencer: RTL and testbench

Battle-turn attack sequencer: consumes the 2-bit stream from the game's LFSR random source and turns it into a timed enemy attack turn. Each turn picks an attack ID, shows a warning phase, runs the attack phase and a cooldown, then reports completion. It sits between the battle control FSM, which issues `start_turn` and `abort`, and the attack renderers, which consume `attack_id`, `warn` and `attack_active`.

---
 rtl/battle_pkg.sv | 37 +++
 rtl/phase_timer.sv | 39 +++
 rtl/attack_sequencer.sv | 172 +++++++++++++++++
 tb/tb_attack_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// battle_pkg: types and constants shared by the battle-turn logic.
// Holds the attack sequencer state enum, the attack ID type and the
// named attack IDs, and small helpers used to size and step values.
package battle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PICK     = 3'd1,
    ST_WARN     = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_COOLDOWN = 3'd4
  } seq_state_t;

  typedef logic [1:0] attack_id_t;

  localparam attack_id_t ATK_BONES   = 2'd0;
  localparam attack_id_t ATK_BLASTER = 2'd1;
  localparam attack_id_t ATK_SPEARS  = 2'd2;
  localparam attack_id_t ATK_RAIN    = 2'd3;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Next attack ID in the ring of four, wrapping ATK_RAIN back to ATK_BONES.
  function automatic attack_id_t next_attack(input attack_id_t id);
    return id + 2'd1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter shared by every phase of a turn.
// load copies value into the counter; otherwise it counts down to zero
// and stops. expire is high while the count is 1, i.e. in the last cycle
// of the phase that was loaded, so the owner can change phase on that edge.
module phase_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload wins, else decrement until the counter rests at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == WIDTH'(1));

endmodule

// File: rtl/attack_sequencer.sv
// attack_sequencer: turns a start request plus the 2-bit LFSR value into a
// timed enemy attack turn (PICK, WARN, ACTIVE, COOLDOWN), then reports
// completion with turn_done and a wrapping turn_count. All outputs are
// registered. Optional macro ATTACK_NO_REPEAT_EN stops two consecutive
// turns from picking the same attack ID.
module attack_sequencer
  import battle_pkg::*;
#(
  parameter int unsigned WARN_CYCLES     = 25_000_000,
  parameter int unsigned ACTIVE_CYCLES   = 150_000_000,
  parameter int unsigned COOLDOWN_CYCLES = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] random_num,
  input  logic       start_turn,
  input  logic       abort,
  output logic [1:0] attack_id,
  output logic       warn,
  output logic       attack_active,
  output logic       busy,
  output logic       turn_done,
  output logic [7:0] turn_count
);

  localparam int unsigned MAX_CYCLES = max3(WARN_CYCLES, ACTIVE_CYCLES, COOLDOWN_CYCLES);
  localparam int TIMER_W = $clog2(MAX_CYCLES) + 1;

  seq_state_t state_q, state_d;
  attack_id_t attack_id_q, attack_id_d;
  logic       warn_q, warn_d;
  logic       active_q, active_d;
  logic       busy_q, busy_d;
  logic       turn_done_q, turn_done_d;
  logic [7:0] turn_count_q, turn_count_d;

  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expire;
  attack_id_t         pick_id;

  phase_timer #(
    .WIDTH(TIMER_W)
  ) u_phase_timer (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .load   (timer_load),
    .value  (timer_value),
    .expire (timer_expire)
  );

`ifdef ATTACK_NO_REPEAT_EN
  attack_id_t last_id_q, last_id_d;
  logic       last_valid_q, last_valid_d;

  // Bump the random pick by one when it would repeat the previous turn's ID.
  always_comb begin
    pick_id = random_num;
    if (last_valid_q && (random_num == last_id_q)) begin
      pick_id = next_attack(last_id_q);
    end
  end

  // Remember the ID of the last completed pick; abort leaves it untouched.
  always_comb begin
    last_id_d    = last_id_q;
    last_valid_d = last_valid_q;
    if ((state_q == ST_PICK) && !abort) begin
      last_id_d    = pick_id;
      last_valid_d = 1'b1;
    end
  end

  // Last-pick history registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      last_id_q    <= ATK_BONES;
      last_valid_q <= 1'b0;
    end else begin
      last_id_q    <= last_id_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign pick_id = random_num;
`endif

  // Next state, timer reloads, pick, completion, then outputs from the next state.
  always_comb begin
    state_d      = state_q;
    attack_id_d  = attack_id_q;
    turn_done_d  = 1'b0;
    turn_count_d = turn_count_q;
    timer_load   = 1'b0;
    timer_value  = '0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_turn) begin
            state_d = ST_PICK;
          end
        end
        ST_PICK: begin
          attack_id_d = pick_id;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(WARN_CYCLES);
          state_d     = ST_WARN;
        end
        ST_WARN: begin
          if (timer_expire) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(ACTIVE_CYCLES);
            state_d     = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (timer_expire) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(COOLDOWN_CYCLES);
            state_d     = ST_COOLDOWN;
          end
        end
        ST_COOLDOWN: begin
          if (timer_expire) begin
            turn_done_d  = 1'b1;
            turn_count_d = turn_count_q + 8'd1;
            state_d      = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    warn_d   = (state_d == ST_WARN);
    active_d = (state_d == ST_ACTIVE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State and registered outputs, all cleared asynchronously.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      attack_id_q  <= ATK_BONES;
      warn_q       <= 1'b0;
      active_q     <= 1'b0;
      busy_q       <= 1'b0;
      turn_done_q  <= 1'b0;
      turn_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      attack_id_q  <= attack_id_d;
      warn_q       <= warn_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      turn_done_q  <= turn_done_d;
      turn_count_q <= turn_count_d;
    end
  end

  assign attack_id     = attack_id_q;
  assign warn          = warn_q;
  assign attack_active = active_q;
  assign busy          = busy_q;
  assign turn_done     = turn_done_q;
  assign turn_count    = turn_count_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// tb_attack_sequencer: directed bench for attack_sequencer with W=2, A=3, C=1.
// A turn-level model tracks how many edges have passed since a turn was
// accepted and derives every output from that count; a per-cycle compare
// checks the DUT against it, and literal checks pin key cycles by hand.
// Honours ATTACK_NO_REPEAT_EN the same way the design does.
module tb_attack_sequencer;

  localparam int W        = 2;
  localparam int A        = 3;
  localparam int C        = 1;
  localparam int TURN_LEN = W + A + C;

  logic       CLOCK_50;
  logic       resetn;
  logic [1:0] random_num;
  logic       start_turn;
  logic       abort;
  logic [1:0] attack_id;
  logic       warn;
  logic       attack_active;
  logic       busy;
  logic       turn_done;
  logic [7:0] turn_count;

  int checks;
  int failures;

  // Model state: whether a turn is running and how many edges since acceptance.
  bit m_in_turn;
  int m_k;
  int m_id;
  bit m_done;
  int m_count;
  int m_last_id;
  bit m_last_valid;

  attack_sequencer #(
    .WARN_CYCLES    (W),
    .ACTIVE_CYCLES  (A),
    .COOLDOWN_CYCLES(C)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .random_num   (random_num),
    .start_turn   (start_turn),
    .abort        (abort),
    .attack_id    (attack_id),
    .warn         (warn),
    .attack_active(attack_active),
    .busy         (busy),
    .turn_done    (turn_done),
    .turn_count   (turn_count)
  );

  // 10-time-unit clock.
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Attack ID chosen for a turn from the random value and the previous pick.
  function automatic int expected_pick(input int rnd, input int last, input bit valid);
`ifdef ATTACK_NO_REPEAT_EN
    if (valid && (rnd == last)) return (rnd + 1) % 4;
`endif
    return rnd;
  endfunction

  // Turn-level reference: edge 0 accepts, pick on edge 1, turn ends on edge TURN_LEN+1.
  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      m_in_turn    <= 1'b0;
      m_k          <= 0;
      m_id         <= 0;
      m_done       <= 1'b0;
      m_count      <= 0;
      m_last_id    <= 0;
      m_last_valid <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_in_turn) begin
        if (start_turn && !abort) begin
          m_in_turn <= 1'b1;
          m_k       <= 0;
        end
      end else if (abort) begin
        m_in_turn <= 1'b0;
      end else if (m_k == TURN_LEN) begin
        m_in_turn <= 1'b0;
        m_done    <= 1'b1;
        m_count   <= (m_count + 1) % 256;
      end else begin
        if (m_k == 0) begin
          m_id         <= expected_pick(int'(random_num), m_last_id, m_last_valid);
          m_last_id    <= expected_pick(int'(random_num), m_last_id, m_last_valid);
          m_last_valid <= 1'b1;
        end
        m_k <= m_k + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic applyStimulus(input bit start, input bit abrt, input int rnd);
    start_turn = start;
    abort      = abrt;
    random_num = rnd[1:0];
  endtask

  // Run one complete turn and stop on its turn_done cycle, with a cycle budget.
  task automatic runTurn(input int rnd);
    bit seen;
    seen = 1'b0;
    applyStimulus(1'b1, 1'b0, rnd);
    tick();
    applyStimulus(1'b0, 1'b0, rnd);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (turn_done === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("turn_timeout", 0, 1);
  endtask

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge CLOCK_50);
      checkOutput("cyc_busy", int'(busy), int'(m_in_turn));
      checkOutput("cyc_warn", int'(warn), int'(m_in_turn && m_k >= 1 && m_k <= W));
      checkOutput("cyc_active", int'(attack_active),
                  int'(m_in_turn && m_k >= W + 1 && m_k <= W + A));
      checkOutput("cyc_turn_done", int'(turn_done), int'(m_done));
      checkOutput("cyc_turn_count", int'(turn_count), m_count);
      checkOutput("cyc_attack_id", int'(attack_id), m_id);
    end
  end

  // Directed scenarios with literal expectations.
  initial begin
    int done_seen;
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    applyStimulus(1'b0, 1'b0, 0);

    #2;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_turn_count", int'(turn_count), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // Basic turn, random_num=2.
    applyStimulus(1'b1, 1'b0, 2);
    tick();
    checkOutput("basic_e0_busy", int'(busy), 1);
    checkOutput("basic_e0_warn", int'(warn), 0);
    applyStimulus(1'b0, 1'b0, 2);
    tick();
    checkOutput("basic_e1_id", int'(attack_id), 2);
    checkOutput("basic_e1_warn", int'(warn), 1);
    tick();
    checkOutput("basic_e2_warn", int'(warn), 1);
    tick();
    checkOutput("basic_e3_warn", int'(warn), 0);
    checkOutput("basic_e3_active", int'(attack_active), 1);
    tick();
    tick();
    checkOutput("basic_e5_active", int'(attack_active), 1);
    tick();
    checkOutput("basic_e6_active", int'(attack_active), 0);
    checkOutput("basic_e6_busy", int'(busy), 1);
    checkOutput("basic_e6_done", int'(turn_done), 0);
    tick();
    checkOutput("basic_e7_done", int'(turn_done), 1);
    checkOutput("basic_e7_busy", int'(busy), 0);
    checkOutput("basic_e7_count", int'(turn_count), 1);
    tick();
    checkOutput("basic_e8_done", int'(turn_done), 0);

    // Abort in the second WARN cycle.
    applyStimulus(1'b1, 1'b0, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1);
    tick();
    tick();
    checkOutput("abort_pre_warn", int'(warn), 1);
    applyStimulus(1'b0, 1'b1, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_warn", int'(warn), 0);
    checkOutput("abort_done", int'(turn_done), 0);
    checkOutput("abort_count", int'(turn_count), 1);
    checkOutput("abort_id_hold", int'(attack_id), 1);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("abort_no_done_later", int'(turn_done), 0);

    // start_turn held across a whole turn: one turn, then a new PICK on turn_done.
    done_seen = 0;
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (turn_done === 1'b1) done_seen++;
    end
    checkOutput("hold_done_pulses", done_seen, 1);
    checkOutput("hold_e7_done", int'(turn_done), 1);
    checkOutput("hold_count", int'(turn_count), 2);
    tick();
    checkOutput("hold_repick_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 0);
    tick();
    checkOutput("hold_abort_pick_busy", int'(busy), 0);
    checkOutput("hold_id", int'(attack_id), 0);

    // start_turn together with abort in IDLE stays in IDLE.
    applyStimulus(1'b1, 1'b1, 2);
    tick();
    checkOutput("simul_busy_1", int'(busy), 0);
    tick();
    checkOutput("simul_busy_2", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 2);
    tick();

    // Reset in the middle of ACTIVE, asynchronous.
    applyStimulus(1'b1, 1'b0, 2);
    tick();
    applyStimulus(1'b0, 1'b0, 2);
    tick();
    tick();
    tick();
    checkOutput("rst_pre_active", int'(attack_active), 1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_async_id", int'(attack_id), 0);
    checkOutput("rst_async_warn", int'(warn), 0);
    checkOutput("rst_async_active", int'(attack_active), 0);
    checkOutput("rst_async_busy", int'(busy), 0);
    checkOutput("rst_async_done", int'(turn_done), 0);
    checkOutput("rst_async_count", int'(turn_count), 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    runTurn(1);
    checkOutput("rst_after_count", int'(turn_count), 1);
    checkOutput("rst_after_id", int'(attack_id), 1);

    // Two consecutive turns with random_num=3.
    runTurn(3);
    checkOutput("norep_first_id", int'(attack_id), 3);
    runTurn(3);
`ifdef ATTACK_NO_REPEAT_EN
    checkOutput("norep_second_id", int'(attack_id), 0);
`else
    checkOutput("norep_second_id", int'(attack_id), 3);
`endif
    checkOutput("norep_count", int'(turn_count), 3);
    tick();

    // 256 turns from reset bring turn_count back to 0.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 255; i++) runTurn(i % 4);
    checkOutput("wrap_255", int'(turn_count), 255);
    runTurn(1);
    checkOutput("wrap_0", int'(turn_count), 0);
    checkOutput("wrap_done", int'(turn_done), 1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
